video_frame_arbiter: RTL and testbench

VIDEO_FRAME_ARBITER -- requirements
Module: video_frame_arbiter

---
 rtl/video_frame_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_video_frame_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : video_frame_arbiter
// Description : Frame-granular arbiter between two Avalon-ST video sources
//               (A = test pattern, B = frame reader) feeding one output,
//               with an Avalon-MM CSR slave for control, status and counters.
// Revision    : 1.0 - initial release
// ============================================================================
module video_frame_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             clock_sreset,
  // CSR slave
  input  logic [3:0]       s_address,
  input  logic [31:0]      s_writedata,
  output logic [31:0]      s_readdata,
  input  logic             s_read,
  input  logic             s_write,
  output logic             s_waitrequest,
  // source A
  output logic             a_ready,
  input  logic             a_valid,
  input  logic             a_sop,
  input  logic             a_eop,
  input  logic [WIDTH-1:0] a_data,
  // source B
  output logic             b_ready,
  input  logic             b_valid,
  input  logic             b_sop,
  input  logic             b_eop,
  input  logic [WIDTH-1:0] b_data,
  // arbitrated output
  input  logic             st_ready,
  output logic             st_valid,
  output logic             st_sop,
  output logic             st_eop,
  output logic [WIDTH-1:0] st_data
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARB  = 2'd1;
  localparam logic [1:0] ST_SYNC = 2'd2;
  localparam logic [1:0] ST_XFER = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [2:0]  control;
  logic [15:0] frames_out;
  logic [15:0] discards;
  logic        grant;
  logic        last_grant;
  logic        rd_pending;

  logic        enable;
  logic        auto_mode;
  logic        sel;
  logic        g_valid;
  logic        g_sop;
  logic        g_eop;
  logic [WIDTH-1:0] g_data;
  logic        pref;
  logic        pref_valid;
  logic        last_valid;
  logic        arb_ok;
  logic        arb_pick;
  logic        discard_evt;
  logic        frame_evt;
  logic        clear_cnt;
  logic        rd_start;
  logic [31:0] read_val;
  logic        unused_writedata;

  assign enable    = control[0];
  assign auto_mode = control[1];
  assign sel       = control[2];
  assign unused_writedata = ^s_writedata[31:3];

  // Signals of whichever source currently holds the grant
  assign g_valid = grant ? b_valid : a_valid;
  assign g_sop   = grant ? b_sop   : a_sop;
  assign g_eop   = grant ? b_eop   : a_eop;
  assign g_data  = grant ? b_data  : a_data;

  // Auto mode prefers the other source, falls back to the last one
  assign pref       = ~last_grant;
  assign pref_valid = pref ? b_valid : a_valid;
  assign last_valid = last_grant ? b_valid : a_valid;
  assign arb_ok     = auto_mode ? (pref_valid | last_valid) : 1'b1;
  assign arb_pick   = auto_mode ? (pref_valid ? pref : last_grant) : sel;

  assign discard_evt = (state == ST_SYNC) && g_valid && !g_sop;
  assign frame_evt   = (state == ST_XFER) && g_valid && st_ready && g_eop;
  assign clear_cnt   = s_write && (s_address == 4'h2);

  // Reads stall one cycle so the read data can be registered
  assign rd_start      = s_read && !s_write && !rd_pending;
  assign s_waitrequest = rd_start;

  // State register
  always_ff @(posedge clock) begin
    if (clock_sreset) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  // Next-state logic; control is only sampled at frame boundaries
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (enable) state_nxt = ST_ARB;
      ST_ARB: begin
        if (!enable)     state_nxt = ST_IDLE;
        else if (arb_ok) state_nxt = ST_SYNC;
      end
      ST_SYNC: if (g_valid && g_sop) state_nxt = ST_XFER;
      ST_XFER: if (frame_evt) state_nxt = ST_ARB;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic; the sop beat is held back in SYNC so XFER forwards it
  always_comb begin
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    st_valid = 1'b0;
    st_sop   = 1'b0;
    st_eop   = 1'b0;
    st_data  = '0;
    case (state)
      ST_SYNC: begin
        if (grant) b_ready = ~b_sop;
        else       a_ready = ~a_sop;
      end
      ST_XFER: begin
        st_valid = g_valid;
        st_sop   = g_sop;
        st_eop   = g_eop;
        st_data  = g_data;
        if (grant) b_ready = st_ready;
        else       a_ready = st_ready;
      end
      default: ;
    endcase
  end

  // Grant bookkeeping
  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (state == ST_ARB && enable && arb_ok) grant <= arb_pick;
      if (frame_evt) last_grant <= grant;
    end
  end

  // Control register and event counters
  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      control    <= 3'd0;
      frames_out <= 16'd0;
      discards   <= 16'd0;
    end else begin
      if (s_write && s_address == 4'h0) control <= s_writedata[2:0];
      if (clear_cnt)      frames_out <= 16'd0;
      else if (frame_evt) frames_out <= frames_out + 16'd1;
      if (clear_cnt)        discards <= 16'd0;
      else if (discard_evt) discards <= discards + 16'd1;
    end
  end

  // CSR read mux
  always_comb begin
    read_val = 32'd0;
    case (s_address)
      4'h0: read_val = {29'd0, control};
      4'h1: read_val = {30'd0, grant, (state != ST_IDLE)};
      4'h2: read_val = {16'd0, frames_out};
      4'h3: read_val = {16'd0, discards};
      default: read_val = 32'd0;
    endcase
  end

  // Registered read data, presented when waitrequest drops
  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      s_readdata <= 32'd0;
      rd_pending <= 1'b0;
    end else if (rd_start) begin
      s_readdata <= read_val;
      rd_pending <= 1'b1;
    end else begin
      rd_pending <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_frame_arbiter
// Description : Self-checking bench for video_frame_arbiter. Sources are fed
//               from beat queues; expected output is a frame-order queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_frame_arbiter;
  localparam int WIDTH = 16;

  logic clock = 1'b0;
  logic clock_sreset;
  logic [3:0] s_address;
  logic [31:0] s_writedata, s_readdata;
  logic s_read, s_write, s_waitrequest;
  logic a_ready, a_valid, a_sop, a_eop;
  logic [WIDTH-1:0] a_data;
  logic b_ready, b_valid, b_sop, b_eop;
  logic [WIDTH-1:0] b_data;
  logic st_ready, st_valid, st_sop, st_eop;
  logic [WIDTH-1:0] st_data;

  always #5 clock = ~clock;

  video_frame_arbiter #(.WIDTH(WIDTH)) dut (
    .clock(clock), .clock_sreset(clock_sreset),
    .s_address(s_address), .s_writedata(s_writedata), .s_readdata(s_readdata),
    .s_read(s_read), .s_write(s_write), .s_waitrequest(s_waitrequest),
    .a_ready(a_ready), .a_valid(a_valid), .a_sop(a_sop), .a_eop(a_eop), .a_data(a_data),
    .b_ready(b_ready), .b_valid(b_valid), .b_sop(b_sop), .b_eop(b_eop), .b_data(b_data),
    .st_ready(st_ready), .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop), .st_data(st_data)
  );

  typedef struct packed {
    logic sop;
    logic eop;
    logic [WIDTH-1:0] data;
  } beat_t;

  beat_t a_q[$], b_q[$], exp_q[$];
  int total = 0;
  int bad = 0;
  int a_pct, b_pct, rdy_pct;
  int only_src;            // 0: only A may be readied, 1: only B, 2: either
  logic samp_wait;
  logic [31:0] samp_rdata;

  // Append one frame to a source queue; optionally expect it at the output
  task automatic add_frame(input int src, input int len, input bit expect_out);
    beat_t bt;
    for (int i = 0; i < len; i++) begin
      bt.sop  = (i == 0);
      bt.eop  = (i == len - 1);
      bt.data = WIDTH'($urandom);
      bt.data[WIDTH-1] = src[0];
      if (src == 0) a_q.push_back(bt); else b_q.push_back(bt);
      if (expect_out) exp_q.push_back(bt);
    end
  endtask

  // One clock: drive at the falling edge, sample 1 time unit later
  task automatic step();
    beat_t exp_b;
    a_valid = (a_q.size() > 0) && ($urandom_range(99) < a_pct);
    {a_sop, a_eop, a_data} = (a_q.size() > 0) ? a_q[0] : '0;
    b_valid = (b_q.size() > 0) && ($urandom_range(99) < b_pct);
    {b_sop, b_eop, b_data} = (b_q.size() > 0) ? b_q[0] : '0;
    st_ready = ($urandom_range(99) < rdy_pct);
    #1;
    samp_wait  = s_waitrequest;
    samp_rdata = s_readdata;
    if (a_ready || b_ready) begin
      total++;
      if ((a_ready && b_ready) || (only_src == 0 && b_ready) || (only_src == 1 && a_ready)) begin
        bad++;
        $display("FAIL ready_exclusive: a_ready=%0b b_ready=%0b allowed_src=%0d", a_ready, b_ready, only_src);
      end
    end
    if (a_valid && a_ready) void'(a_q.pop_front());
    if (b_valid && b_ready) void'(b_q.pop_front());
    if (st_valid && st_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_beat: got sop=%0b eop=%0b data=%h, expected no beat", st_sop, st_eop, st_data);
      end else begin
        exp_b = exp_q.pop_front();
        if ({st_sop, st_eop, st_data} !== exp_b)
          begin
            bad++;
            $display("FAIL out_beat: got sop=%0b eop=%0b data=%h, expected sop=%0b eop=%0b data=%h",
                     st_sop, st_eop, st_data, exp_b.sop, exp_b.eop, exp_b.data);
          end
      end
    end
    @(negedge clock);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3000 && exp_q.size() > 0; i++) step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d beats still outstanding, expected 0", name, exp_q.size());
    end
  endtask

  task automatic csr_write(input logic [3:0] addr, input logic [31:0] data);
    s_write = 1'b1; s_address = addr; s_writedata = data;
    step();
    s_write = 1'b0;
    total++;
    if (samp_wait !== 1'b0) begin
      bad++;
      $display("FAIL write_wait: waitrequest=%b expected 0", samp_wait);
    end
  endtask

  task automatic csr_read(input logic [3:0] addr, output logic [31:0] data);
    logic w1;
    s_read = 1'b1; s_address = addr;
    step();
    w1 = samp_wait;
    step();
    data = samp_rdata;
    s_read = 1'b0;
    total++;
    if (w1 !== 1'b1 || samp_wait !== 1'b0) begin
      bad++;
      $display("FAIL read_wait addr=%0d: waitrequest=%b,%b expected 1,0", addr, w1, samp_wait);
    end
  endtask

  task automatic do_reset();
    a_q.delete(); b_q.delete(); exp_q.delete();
    clock_sreset = 1'b1;
    step(); step();
    clock_sreset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    clock_sreset = 1'b1;
    step(); step();
    total++;
    if ({st_valid, st_sop, st_eop, a_ready, b_ready} !== 5'b0 || s_readdata !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs: v/sop/eop/ar/br=%b rdata=%h expected 0", {st_valid, st_sop, st_eop, a_ready, b_ready}, s_readdata);
    end
    clock_sreset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      csr_read(4'(a), d);
      total++;
      if (d !== 32'd0) begin bad++; $display("FAIL reset_csr%0d: got %h expected 0", a, d); end
    end
  endtask

  task automatic test_fixed_a();
    logic [31:0] d;
    beat_t bt;
    do_reset();
    only_src = 0; a_pct = 100; b_pct = 100; rdy_pct = 100;
    bt = {1'b1, 1'b0, 16'd640};    a_q.push_back(bt); exp_q.push_back(bt);
    bt = {1'b0, 1'b0, 16'd480};    a_q.push_back(bt); exp_q.push_back(bt);
    bt = {1'b0, 1'b1, 16'hF81F};   a_q.push_back(bt); exp_q.push_back(bt);
    add_frame(1, 4, 0);
    csr_write(4'h0, 32'h1);
    drain("fixed_a_first");
    csr_read(4'h2, d);
    total++;
    if (d !== 32'd1) begin bad++; $display("FAIL fixed_a_frames1: got %0d expected 1", d); end
    for (int f = 0; f < 3; f++) add_frame(0, $urandom_range(1, 6), 1);
    a_pct = $urandom_range(50, 100); rdy_pct = $urandom_range(30, 100);
    drain("fixed_a_random");
    csr_read(4'h2, d);
    total++;
    if (d !== 32'd4) begin bad++; $display("FAIL fixed_a_frames4: got %0d expected 4", d); end
  endtask

  task automatic test_auto();
    logic [31:0] d;
    do_reset();
    only_src = 2; a_pct = 100; b_pct = 100; rdy_pct = $urandom_range(40, 100);
    for (int f = 0; f < 4; f++) add_frame(f % 2, $urandom_range(1, 6), 1);
    csr_write(4'h0, 32'h3);
    drain("auto_alt");
    csr_read(4'h2, d);
    total++;
    if (d !== 32'd4) begin bad++; $display("FAIL auto_frames: got %0d expected 4", d); end
    csr_read(4'h1, d);
    total++;
    if (d !== 32'd3) begin bad++; $display("FAIL auto_status_b: got %h expected 3", d); end
    add_frame(0, $urandom_range(1, 5), 1);
    drain("auto_a");
    csr_read(4'h1, d);
    total++;
    if (d !== 32'd1) begin bad++; $display("FAIL auto_status_a: got %h expected 1", d); end
    add_frame(1, $urandom_range(1, 5), 1);
    drain("auto_b");
    add_frame(1, $urandom_range(1, 5), 1);
    drain("auto_fallback");
    csr_read(4'h1, d);
    total++;
    if (d !== 32'd3) begin bad++; $display("FAIL auto_status_fb: got %h expected 3", d); end
    csr_read(4'h2, d);
    total++;
    if (d !== 32'd7) begin bad++; $display("FAIL auto_frames7: got %0d expected 7", d); end
  endtask

  task automatic test_discard();
    logic [31:0] d;
    beat_t bt;
    do_reset();
    only_src = 0; a_pct = $urandom_range(40, 100); rdy_pct = $urandom_range(40, 100);
    for (int i = 0; i < 2; i++) begin
      bt.sop = 1'b0; bt.eop = 1'b0; bt.data = WIDTH'($urandom);
      a_q.push_back(bt);
    end
    add_frame(0, $urandom_range(2, 6), 1);
    csr_write(4'h0, 32'h1);
    drain("discard");
    csr_read(4'h3, d);
    total++;
    if (d !== 32'd2) begin bad++; $display("FAIL discard_count: got %0d expected 2", d); end
  endtask

  task automatic test_csr();
    logic [31:0] d;
    csr_read(4'h2, d);
    total++;
    if (d !== 32'd1) begin bad++; $display("FAIL csr_frames: got %0d expected 1", d); end
    csr_read(4'h0, d);
    total++;
    if (d !== 32'd1) begin bad++; $display("FAIL csr_control: got %h expected 1", d); end
    csr_read(4'h5, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL csr_unmapped: got %h expected 0", d); end
    csr_write(4'h2, 32'h0);
    csr_read(4'h2, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL csr_clear_frames: got %0d expected 0", d); end
    csr_read(4'h3, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL csr_clear_discards: got %0d expected 0", d); end
  endtask

  task automatic test_sel_switch();
    logic [31:0] d;
    int n0;
    do_reset();
    only_src = 2; a_pct = 100; b_pct = 100; rdy_pct = 50;
    add_frame(0, 8, 1);
    add_frame(0, 4, 0);
    add_frame(1, $urandom_range(2, 6), 1);
    n0 = exp_q.size();
    csr_write(4'h0, 32'h1);
    for (int i = 0; i < 500 && exp_q.size() > n0 - 2; i++) step();
    csr_write(4'h0, 32'h5);
    drain("sel_switch");
    csr_read(4'h2, d);
    total++;
    if (d !== 32'd2) begin bad++; $display("FAIL sel_switch_frames: got %0d expected 2", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    do_reset();
    only_src = 0; a_pct = 100; rdy_pct = 100;
    add_frame(0, 10, 1);
    csr_write(4'h0, 32'h1);
    for (int i = 0; i < 200 && exp_q.size() > 7; i++) step();
    clock_sreset = 1'b1;
    step();
    a_valid = 1'b1; a_sop = 1'b0; a_eop = 1'b0; st_ready = 1'b1;
    #1;
    total++;
    if ({st_valid, st_sop, st_eop, a_ready, b_ready} !== 5'b0) begin
      bad++;
      $display("FAIL reset_mid_outputs: v/sop/eop/ar/br=%b expected 0", {st_valid, st_sop, st_eop, a_ready, b_ready});
    end
    a_q.delete(); b_q.delete(); exp_q.delete();
    @(negedge clock);
    clock_sreset = 1'b0;
    for (int a = 0; a < 3; a++) begin
      csr_read(4'(a), d);
      total++;
      if (d !== 32'd0) begin bad++; $display("FAIL reset_mid_csr%0d: got %h expected 0", a, d); end
    end
  endtask

  initial begin
    clock_sreset = 1'b1;
    s_address = '0; s_writedata = '0; s_read = 1'b0; s_write = 1'b0;
    a_valid = 1'b0; a_sop = 1'b0; a_eop = 1'b0; a_data = '0;
    b_valid = 1'b0; b_sop = 1'b0; b_eop = 1'b0; b_data = '0;
    st_ready = 1'b0;
    a_pct = 100; b_pct = 100; rdy_pct = 100; only_src = 2;
    @(negedge clock);
    test_reset();
    test_fixed_a();
    test_auto();
    test_discard();
    test_csr();
    test_sel_switch();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
